// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin merge of tile and NoC trace strobes
// onto the single trace buffer write port, with capture session control.
module trace_arbiter #(
  parameter int N_SRC = 5,
  parameter int Fpay  = 32,
  parameter int SRCw  = 3,
  parameter int CNTw  = 10,
  parameter int DRPw  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        trig,
  input  logic [N_SRC*Fpay-1:0]   trace_in_all,
  input  logic [N_SRC-1:0]        src_mask,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic [CNTw-1:0]         stop_count,
  input  logic                    tb_full,
  output logic                    tb_wr,
  output logic [Fpay-1:0]         tb_din,
  output logic [SRCw-1:0]         tb_src,
  output logic [CNTw-1:0]         word_cnt,
  output logic [N_SRC*DRPw-1:0]   drop_cnt_all,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    STOPPED = 2'b10
  } st_t;

  localparam logic [CNTw-1:0] CNT_MAX  = '1;
  localparam logic [DRPw-1:0] DRP_MAX  = '1;
  localparam logic [SRCw-1:0] PTR_INIT = SRCw'(N_SRC - 1);

  st_t              st;
  logic [N_SRC-1:0] pend;
  logic [Fpay-1:0]  hold [N_SRC];
  logic [DRPw-1:0]  drop [N_SRC];
  logic [Fpay-1:0]  din  [N_SRC];
  logic [SRCw-1:0]  ptr;

  logic [N_SRC-1:0] cap;
  logic             gnt_ok;
  logic [SRCw-1:0]  gnt_idx;
  logic [CNTw-1:0]  cnt_nxt;
  logic             limit_hit;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_lane
    assign din[gi] = trace_in_all[gi*Fpay +: Fpay];
    assign drop_cnt_all[gi*DRPw +: DRPw] = drop[gi];
  end

  assign state = st;
  assign cap   = (st == ARMED) ? (trig & src_mask) : '0;

  // first pending source above the pointer, wrapping
  always_comb begin
    int j;
    j       = 0;
    gnt_ok  = 1'b0;
    gnt_idx = ptr;
    for (int k = 1; k <= N_SRC; k++) begin
      j = (int'(ptr) + k) % N_SRC;
      if (!gnt_ok && pend[j]) begin
        gnt_ok  = 1'b1;
        gnt_idx = SRCw'(j);
      end
    end
    if (st != ARMED || tb_full) begin
      gnt_ok = 1'b0;
    end
  end

  assign cnt_nxt   = (word_cnt == CNT_MAX) ? word_cnt
                                           : word_cnt + 1'b1;
  assign limit_hit = gnt_ok && (stop_count != '0)
                  && (cnt_nxt == stop_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      tb_wr    <= 1'b0;
      tb_din   <= '0;
      tb_src   <= '0;
      word_cnt <= '0;
      pend     <= '0;
      ptr      <= PTR_INIT;
      for (int n = 0; n < N_SRC; n++) begin
        hold[n] <= '0;
        drop[n] <= '0;
      end
    end else begin
      tb_wr <= 1'b0;
      unique case (st)
        IDLE, STOPPED: begin
          if (disarm) begin
            st <= STOPPED;
          end else if (arm) begin
            st       <= ARMED;
            word_cnt <= '0;
            pend     <= '0;
            for (int n = 0; n < N_SRC; n++) begin
              drop[n] <= '0;
            end
          end
        end
        ARMED: begin
          if (gnt_ok) begin
            tb_wr    <= 1'b1;
            tb_din   <= hold[gnt_idx];
            tb_src   <= gnt_idx;
            ptr      <= gnt_idx;
            word_cnt <= cnt_nxt;
          end
          // a granted slot frees itself this edge, so a new strobe refills it
          for (int n = 0; n < N_SRC; n++) begin
            if (cap[n]) begin
              if (pend[n] && !(gnt_ok && gnt_idx == SRCw'(n))) begin
                if (drop[n] != DRP_MAX) begin
                  drop[n] <= drop[n] + 1'b1;
                end
              end else begin
                hold[n] <= din[n];
                pend[n] <= 1'b1;
              end
            end else if (gnt_ok && gnt_idx == SRCw'(n)) begin
              pend[n] <= 1'b0;
            end
          end
          if (disarm || tb_full || limit_hit) begin
            st <= STOPPED;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
